// File: rtl/fpu_add_issuer.sv
// Issue front end for the multi-cycle FP32 adder: tagged command FIFO, one op in flight, result port, watchdog.
// Optional result classification flags are built when FPU_ISSUE_FLAGS_EN is defined.
module fpu_add_issuer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [31:0]                   cmd_a,
    input  logic [31:0]                   cmd_b,
    input  logic                          cmd_sub,
    input  logic [TAG_W-1:0]              cmd_tag,
    output logic [31:0]                   fpu_a,
    output logic [31:0]                   fpu_b,
    output logic                          fpu_sub,
    output logic                          fpu_enable,
    input  logic [31:0]                   fpu_result,
    input  logic                          fpu_result_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [31:0]                   res_data,
    output logic [TAG_W-1:0]              res_tag,
    output logic                          res_timeout,
    output logic [2:0]                    res_flags,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = 65 + TAG_W;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0] QNAN = 32'hFFC00000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic             push_c, pop_c;
    logic [ENT_W-1:0] head_c;

    logic [2:0]       state_q, state_d;
    logic [31:0]      fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic             fpu_sub_q, fpu_sub_d, fpu_enable_q, fpu_enable_d;
    logic [TAG_W-1:0] tag_q, tag_d, res_tag_q, res_tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stray_q, stray_d;
    logic             res_valid_q, res_valid_d, res_timeout_q, res_timeout_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             cap_c, cap_to_c;
    logic [31:0]      cap_data_c;

    // FIFO bookkeeping; pops only happen when the FSM idles with work queued
    assign push_c = cmd_valid && cmd_ready_q;
    assign pop_c  = (state_q == ST_IDLE) && (count_q != '0);
    assign head_c = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d    = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + LVL_W'(push_c) - LVL_W'(pop_c);
        cmd_ready_d = (count_d != LVL_W'(FIFO_DEPTH));
        busy_d      = (count_d != '0) || (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= {cmd_tag, cmd_sub, cmd_b, cmd_a};
    end

    // Issue FSM; operands stay frozen from launch until the next pop
    always_comb begin
        state_d      = state_q;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
        fpu_sub_d    = fpu_sub_q;
        tag_d        = tag_q;
        fpu_enable_d = 1'b0;
        cnt_d        = cnt_q;
        stray_d      = stray_q;
        res_valid_d  = res_valid_q;
        cap_c        = 1'b0;
        cap_to_c     = 1'b0;
        cap_data_c   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pop_c) begin
                    {tag_d, fpu_sub_d, fpu_b_d, fpu_a_d} = head_c;
                    fpu_enable_d = 1'b1;
                    state_d      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_result_ready) begin
                    cap_c       = 1'b1;
                    cap_data_c  = fpu_result;
                    res_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    cap_c       = 1'b1;
                    cap_data_c  = QNAN;
                    cap_to_c    = 1'b1;
                    res_valid_d = 1'b1;
                    cnt_d       = '0;
                    stray_d     = 1'b0;
                    state_d     = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                // Leave only once the adder is known to be quiet again
                if (res_ready) res_valid_d = 1'b0;
                if (fpu_result_ready) stray_d = 1'b1;
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
                if ((!res_valid_q || res_ready) &&
                    (stray_q || fpu_result_ready || (cnt_q == CNT_LAST))) begin
                    cnt_d   = '0;
                    stray_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        res_data_d    = cap_c ? cap_data_c : res_data_q;
        res_tag_d     = cap_c ? tag_q : res_tag_q;
        res_timeout_d = cap_c ? cap_to_c : res_timeout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            fpu_sub_q     <= 1'b0;
            fpu_enable_q  <= 1'b0;
            tag_q         <= '0;
            cnt_q         <= '0;
            stray_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_tag_q     <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            state_q       <= state_d;
            fpu_a_q       <= fpu_a_d;
            fpu_b_q       <= fpu_b_d;
            fpu_sub_q     <= fpu_sub_d;
            fpu_enable_q  <= fpu_enable_d;
            tag_q         <= tag_d;
            cnt_q         <= cnt_d;
            stray_q       <= stray_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_tag_q     <= res_tag_d;
            res_timeout_q <= res_timeout_d;
        end
    end

`ifdef FPU_ISSUE_FLAGS_EN
    logic [2:0] res_flags_q, res_flags_d;

    function automatic logic [2:0] fp_class(input logic [31:0] v);
        fp_class = {(v[30:23] == 8'hFF) && (v[22:0] != '0),
                    (v[30:23] == 8'hFF) && (v[22:0] == '0),
                    (v[30:23] == 8'h00) && (v[22:0] == '0)};
    endfunction

    always_comb res_flags_d = cap_c ? fp_class(cap_data_c) : res_flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) res_flags_q <= '0;
        else     res_flags_q <= res_flags_d;
    end

    assign res_flags = res_flags_q;
`else
    assign res_flags = 3'b000;
`endif

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign fifo_level  = count_q;
    assign fpu_a       = fpu_a_q;
    assign fpu_b       = fpu_b_q;
    assign fpu_sub     = fpu_sub_q;
    assign fpu_enable  = fpu_enable_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_tag     = res_tag_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_fpu_add_issuer.sv
// Bench for fpu_add_issuer: behavioural adder stub, result scoreboard, and directed scenarios.
module tb_fpu_add_issuer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 4;
    localparam int unsigned TO    = 16;
    localparam logic [31:0] QNAN   = 32'hFFC00000;
    localparam logic [31:0] HANG_A = 32'h3FC0DEAD;
`ifdef FPU_ISSUE_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic          clk, rst;
    logic          cmd_valid, cmd_ready, cmd_sub;
    logic [31:0]   cmd_a, cmd_b;
    logic [TW-1:0] cmd_tag;
    logic [31:0]   fpu_a, fpu_b, fpu_result;
    logic          fpu_sub, fpu_enable, fpu_result_ready;
    logic          res_valid, res_ready, res_timeout, busy;
    logic [31:0]   res_data;
    logic [TW-1:0] res_tag;
    logic [2:0]    res_flags;
    logic [2:0]    fifo_level;

    fpu_add_issuer #(.FIFO_DEPTH(DEPTH), .TAG_W(TW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_sub(cmd_sub), .cmd_tag(cmd_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sub(fpu_sub), .fpu_enable(fpu_enable),
        .fpu_result(fpu_result), .fpu_result_ready(fpu_result_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
        .res_timeout(res_timeout), .res_flags(res_flags), .busy(busy), .fifo_level(fifo_level)
    );

    typedef struct packed {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        logic          to;
        logic [2:0]    flags;
    } exp_t;

    exp_t expq[$];
    int unsigned vecs = 0, errs = 0;
    int ncyc = 0, launch_cyc = 0, en_cycles = 0, n_results = 0, stray_at = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic is_spec(input logic [31:0] v);
        is_spec = (v[30:23] == 8'hFF) || ((v[30:23] == 8'h00) && (v[22:0] == '0));
    endfunction

    function automatic logic [2:0] classify(input logic [31:0] v);
        classify = {(v[30:23] == 8'hFF) && (v[22:0] != '0),
                    (v[30:23] == 8'hFF) && (v[22:0] == '0),
                    (v[30:23] == 8'h00) && (v[22:0] == '0)};
    endfunction

    // Stand-in adder arithmetic: exact for the plan's vectors, arbitrary-but-deterministic otherwise
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b, input logic s);
        if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0)) return QNAN;
        if (s && a == b) return 32'h0;
        if (!s && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (s && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        return s ? a - b : a + b;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   input logic [TW-1:0] t);
        exp_t e;
        e.tag   = t;
        e.to    = (a == HANG_A);
        e.data  = e.to ? QNAN : fake_add(a, b, s);
        e.flags = FLAGS_EN ? classify(e.data) : 3'b000;
        return e;
    endfunction

    // Adder stub: samples on enable, answers after 7 (3 for special) cycles, hangs on HANG_A
    logic ad_pend;
    int   ad_due;
    logic [31:0] ad_res;
    initial begin
        ad_pend = 1'b0; ad_due = 0; ad_res = '0;
        fpu_result = '0; fpu_result_ready = 1'b0;
    end
    always @(posedge clk) begin
        #1;
        fpu_result_ready = 1'b0;
        if (rst) begin
            ad_pend = 1'b0;
        end else begin
            if (ad_pend && ncyc == ad_due) begin
                fpu_result_ready = 1'b1;
                fpu_result       = ad_res;
                ad_pend          = 1'b0;
            end
            if (ncyc == stray_at) begin
                fpu_result_ready = 1'b1;
                fpu_result       = 32'hDEADBEEF;
            end
            if (fpu_enable && fpu_a != HANG_A) begin
                ad_pend = 1'b1;
                ad_due  = ncyc + ((is_spec(fpu_a) || is_spec(fpu_b) || (fpu_sub && fpu_a == fpu_b)) ? 3 : 7);
                ad_res  = fake_add(fpu_a, fpu_b, fpu_sub);
            end
        end
    end

    // Scoreboard and per-cycle protocol checks
    logic prev_en = 1'b0, hold_chk = 1'b0, op_sub;
    logic [31:0] op_a, op_b;
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            hold_chk = 1'b0;
            prev_en  = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) expq.push_back(model(cmd_a, cmd_b, cmd_sub, cmd_tag));
            if (res_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_result", 96'(res_data), 96'(0));
                end else begin
                    chk("sb_data", 96'(res_data), 96'(expq[0].data));
                    chk("sb_tag", 96'(res_tag), 96'(expq[0].tag));
                    chk("sb_timeout", 96'(res_timeout), 96'(expq[0].to));
                    chk("sb_flags", 96'(res_flags), 96'(expq[0].flags));
                    if (res_ready) begin
                        void'(expq.pop_front());
                        n_results++;
                    end
                end
            end
            chk("cmd_ready_vs_level", 96'(cmd_ready), 96'(fifo_level != 3'(DEPTH)));
            if (fpu_enable) begin
                chk("enable_single_cycle", 96'(prev_en), 96'(0));
                en_cycles++;
                launch_cyc = ncyc;
                op_a = fpu_a; op_b = fpu_b; op_sub = fpu_sub;
                hold_chk = 1'b1;
            end else if (hold_chk) begin
                chk("operands_stable", 96'({op_sub, op_b, op_a}), 96'({fpu_sub, fpu_b, fpu_a}));
                if (fpu_result_ready) hold_chk = 1'b0;
            end
            prev_en = fpu_enable;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [TW-1:0] t);
        bit ok = 1'b0;
        int i = 0;
        cmd_a = a; cmd_b = b; cmd_sub = s; cmd_tag = t; cmd_valid = 1'b1;
        while (!ok && i < 400) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
            i++;
        end
        cmd_valid = 1'b0;
        chk("send_accepted", 96'(ok), 96'(1));
    endtask

    task automatic expect_res(input logic [31:0] d, input logic [TW-1:0] t, input logic to,
                              input logic [2:0] f, input string nm, output int vcyc);
        bit ok = 1'b0;
        int i = 0;
        vcyc = 0;
        while (!ok && i < 300) begin
            @(negedge clk);
            if (res_valid) ok = 1'b1;
            i++;
        end
        chk({nm, "_seen"}, 96'(ok), 96'(1));
        if (ok) begin
            vcyc = ncyc;
            chk({nm, "_data"}, 96'(res_data), 96'(d));
            chk({nm, "_tag"}, 96'(res_tag), 96'(t));
            chk({nm, "_timeout"}, 96'(res_timeout), 96'(to));
            chk({nm, "_flags"}, 96'(res_flags), 96'(FLAGS_EN ? f : 3'b000));
            if (res_ready) begin @(posedge clk); #1; end
        end
    endtask

    int vc, prev_vc, en0, nr;
    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sub = 1'b0; cmd_tag = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", 96'(res_valid), 96'(0));
        chk("rst_cmd_ready", 96'(cmd_ready), 96'(1));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_level", 96'(fifo_level), 96'(0));
        chk("rst_enable", 96'(fpu_enable), 96'(0));
        chk("rst_fpu_a", 96'(fpu_a), 96'(0));
        chk("rst_res_data", 96'(res_data), 96'(0));
        chk("rst_flags_timeout_tag", 96'({res_flags, res_timeout, res_tag}), 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        step(2);

        // Add, sub, NaN and A-A through the normal and special latency paths
        res_ready = 1'b1;
        en0 = en_cycles;
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd3);
        expect_res(32'h40400000, 4'd3, 1'b0, 3'b000, "add", vc);
        chk("add_latency", 96'(vc - launch_cyc), 96'(8));
        chk("add_enable_cycles", 96'(en_cycles - en0), 96'(1));
        send(32'h40400000, 32'h3F800000, 1'b1, 4'd5);
        expect_res(32'h40000000, 4'd5, 1'b0, 3'b000, "sub", vc);
        send(32'h7FC00000, 32'h3F800000, 1'b0, 4'd7);
        expect_res(32'hFFC00000, 4'd7, 1'b0, 3'b100, "nan", vc);
        chk("nan_latency", 96'(vc - launch_cyc), 96'(4));
        send(32'h40400000, 32'h40400000, 1'b1, 4'd9);
        expect_res(32'h00000000, 4'd9, 1'b0, 3'b001, "a_minus_a", vc);

        // Backpressure: one held result, full FIFO, sixth command refused
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(32'h41000000 + 32'(i), 32'h3F800000, 1'b0, TW'(i));
        begin
            int w = 0;
            while (!res_valid && w < 100) begin @(negedge clk); w++; end
        end
        @(negedge clk);
        chk("bp_level_full", 96'(fifo_level), 96'(4));
        chk("bp_cmd_ready_low", 96'(cmd_ready), 96'(0));
        chk("bp_busy", 96'(busy), 96'(1));
        @(posedge clk); #1;
        cmd_a = 32'h12345678; cmd_b = 32'h3F800000; cmd_sub = 1'b0; cmd_tag = 4'd6; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_sixth_blocked", 96'(cmd_ready), 96'(0));
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        prev_vc = 0;
        for (int i = 1; i <= 5; i++) begin
            expect_res(32'h80800000 + 32'(i), TW'(i), 1'b0, 3'b000, "bp", vc);
            if (i > 1) chk("bp_spacing", 96'(vc - prev_vc), 96'(10));
            prev_vc = vc;
        end

        // Hung adder, then a stray completion five cycles after the timeout result
        send(HANG_A, 32'h3F800000, 1'b0, 4'd11);
        expect_res(QNAN, 4'd11, 1'b1, 3'b100, "timeout", vc);
        chk("timeout_latency", 96'(vc - launch_cyc), 96'(TO + 1));
        stray_at = vc + 5;
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd12);
        expect_res(32'h40400000, 4'd12, 1'b0, 3'b000, "after_stray", vc);
        chk("launch_after_stray", 96'(launch_cyc > stray_at), 96'(1));

        // Hung adder with no stray: the next launch waits out another watchdog period
        send(HANG_A, 32'h40000000, 1'b0, 4'd13);
        expect_res(QNAN, 4'd13, 1'b1, 3'b100, "timeout2", vc);
        prev_vc = vc;
        send(32'h40400000, 32'h3F800000, 1'b1, 4'd14);
        expect_res(32'h40000000, 4'd14, 1'b0, 3'b000, "after_quiet", vc);
        chk("quiet_period", 96'(launch_cyc - prev_vc >= int'(TO)), 96'(1));

        // Reset while waiting on the adder with two commands queued
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd1);
        send(32'h40400000, 32'h3F800000, 1'b1, 4'd2);
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd3);
        step(2);
        @(negedge clk);
        chk("pre_rst_level", 96'(fifo_level), 96'(2));
        chk("pre_rst_busy", 96'(busy), 96'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_res_valid", 96'(res_valid), 96'(0));
        chk("midrst_level", 96'(fifo_level), 96'(0));
        chk("midrst_cmd_ready", 96'(cmd_ready), 96'(1));
        chk("midrst_busy", 96'(busy), 96'(0));
        chk("midrst_enable", 96'(fpu_enable), 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        nr = n_results;
        step(40);
        chk("post_rst_no_result", 96'(n_results - nr), 96'(0));
        chk("post_rst_idle", 96'({busy, res_valid}), 96'(0));
        chk("scoreboard_drained", 96'(expq.size()), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
